gf128_sqr_reduce: RTL and testbench



---
 rtl/gf128_sqr_reduce.sv | 146 ++++++++++++++
 tb/tb_gf128_sqr_reduce.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf128_sqr_reduce.sv
// gf128_sqr_reduce
//
// Reduces the 256-bit unreduced square produced by the bit-interleave squarer
// modulo P(x) = x^128 + x^7 + x^2 + x + 1, folding FOLD bits per cycle from the
// top of the operand down. The canonical 128-bit result is presented on a
// valid/ready handshake.
//
// Parameters:
//   FOLD       unreduced bits folded per cycle (1, 2, 4, 8, 16, 32 or 64)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   sq_in carries an operand
//   in_ready   block is idle and can accept an operand
//   sq_in      unreduced square, bit i = coefficient of x^i
//   out_valid  res_out carries a result
//   out_ready  consumer accepts the result
//   res_out    reduced result A^2 mod P
//   busy       high while folding
//   odd_err    sticky flag: an accepted operand had an odd bit set
//              (present only when GF_SQR_CHECK_EN is defined)
//
// Build option:
//   GF_SQR_CHECK_EN  adds the odd_err port and its operand check.

module gf128_sqr_reduce #(
    parameter int FOLD = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] sq_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] res_out,
    output logic         busy
`ifdef GF_SQR_CHECK_EN
    ,
    output logic         odd_err
`endif
);

    localparam int NUM_FOLDS = 128 / FOLD;
    localparam int CNT_W     = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [255:0]       w;
    logic [255:0]       w_next;
    logic [CNT_W-1:0]   cnt;
    logic [8:0]         base;
    logic               last_fold;

    // Folds the FOLD-bit chunk whose lowest bit sits at 'base'. Every chunk
    // bit i >= 128 is cleared and x^i is replaced by x^(i-128)*(x^7+x^2+x+1);
    // shifting the isolated chunk down by 128/121/127/126 does that for all
    // chunk bits at once. Landings are at least 121 below the source, so with
    // FOLD <= 64 they never touch the chunk being cleared.
    function automatic logic [255:0] fold_chunk(input logic [255:0] wv,
                                                input logic [8:0]   lo);
        logic [255:0] mask;
        logic [255:0] c;
        mask = {{(256-FOLD){1'b0}}, {FOLD{1'b1}}} << lo;
        c    = wv & mask;
        return (wv & ~mask) ^ (c >> 128) ^ (c >> 121) ^ (c >> 127) ^ (c >> 126);
    endfunction

    // Chunk cnt covers W[255-cnt*FOLD -: FOLD]; its low bit is 256-(cnt+1)*FOLD.
    assign base      = 9'(256 - (int'(cnt) + 1) * FOLD);
    assign w_next    = fold_chunk(w, base);
    assign last_fold = (cnt == CNT_W'(NUM_FOLDS - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (in_valid)  state_nxt = S_FOLD;
            S_FOLD: if (last_fold) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_FOLD);
        out_valid = (state == S_DONE);
    end

    // Working register, fold counter and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w       <= '0;
            cnt     <= '0;
            res_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        w   <= sq_in;
                        cnt <= '0;
                    end
                end
                S_FOLD: begin
                    w   <= w_next;
                    cnt <= cnt + 1'b1;
                    if (last_fold) begin
                        res_out <= w_next[127:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GF_SQR_CHECK_EN
    // A true square has only even-power terms; any odd bit means the
    // upstream squarer misbehaved. The flag latches until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            odd_err <= 1'b0;
        end else if (state == S_IDLE && in_valid && |(sq_in & {128{2'b10}})) begin
            odd_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_gf128_sqr_reduce.sv
module tb_gf128_sqr_reduce;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] sq_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] res_out;
    logic         busy;
`ifdef GF_SQR_CHECK_EN
    logic         odd_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [127:0] exp_q[$];

    gf128_sqr_reduce #(.FOLD(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sq_in     (sq_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res_out   (res_out),
        .busy      (busy)
`ifdef GF_SQR_CHECK_EN
        ,
        .odd_err   (odd_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bit-serial reference: eliminate x^i for i = 255..128 one term at a time.
    function automatic logic [127:0] ref_reduce(input logic [255:0] a);
        logic [255:0] r;
        r = a;
        for (int i = 255; i >= 128; i--) begin
            if (r[i]) begin
                r[i]       = 1'b0;
                r[i - 128] = r[i - 128] ^ 1'b1;
                r[i - 127] = r[i - 127] ^ 1'b1;
                r[i - 126] = r[i - 126] ^ 1'b1;
                r[i - 121] = r[i - 121] ^ 1'b1;
            end
        end
        return r[127:0];
    endfunction

    // Squaring over GF(2) just spreads bits to the even positions.
    function automatic logic [255:0] spread(input logic [127:0] a);
        logic [255:0] s;
        s = '0;
        for (int i = 0; i < 128; i++) s[2*i] = a[i];
        return s;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; presents op until in_ready, returns at the negedge
    // right after the accept edge with the expected result queued.
    task automatic accept_op(input logic [255:0] op, output int acc_cyc, output bit ok);
        ok      = 1'b0;
        acc_cyc = 0;
        in_valid = 1'b1;
        sq_in    = op;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (ok) exp_q.push_back(ref_reduce(op));
    endtask

    task automatic wait_valid(output bit ok, output int seen_cyc);
        ok       = 1'b0;
        seen_cyc = 0;
        for (int k = 0; k < 50; k++) begin
            if (out_valid) begin
                ok       = 1'b1;
                seen_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sq_in = '0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (res_out !== 128'h0) begin errors++; $display("FAIL reset_res_out got %h exp 0", res_out); end
`ifdef GF_SQR_CHECK_EN
        checks++; if (odd_err !== 1'b0)   begin errors++; $display("FAIL reset_odd_err got %b exp 0", odd_err); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [255:0] ops[7];
        logic [127:0] consts[3];
        logic [127:0] e;
        int acc, seen;
        bit ok;
        ops[0] = '0;
        ops[1] = 256'd1 << 128;
        ops[2] = 256'd1 << 254;
        ops[3] = 256'd1 << 255;
        ops[4] = spread(rnd128());
        ops[5] = spread(rnd128());
        ops[6] = spread({128{1'b1}});
        consts[0] = 128'h0;
        consts[1] = 128'h87;
        consts[2] = 128'hC000_0000_0000_0000_0000_0000_0000_1067;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            accept_op(ops[i], acc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL vec%0d_accept got timeout exp in_ready", i); end
            checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL vec%0d_busy got busy=%b in_ready=%b exp 1/0", i, busy, in_ready); end
            wait_valid(ok, seen);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL vec%0d_out_valid got timeout exp out_valid", i);
            end else begin
                checks++; if (seen - acc != 4) begin errors++; $display("FAIL vec%0d_latency got %0d exp 4", i, seen - acc); end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++; if (res_out !== e) begin errors++; $display("FAIL vec%0d_res got %h exp %h", i, res_out, e); end
                if (i < 3) begin
                    checks++; if (res_out !== consts[i]) begin errors++; $display("FAIL vec%0d_const got %h exp %h", i, res_out, consts[i]); end
                end
                @(negedge clk);
                checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL vec%0d_handshake got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0, got = 0, prev = 0, acc;
        logic [255:0] op;
        logic [127:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && got < 5; k++) begin
            if (out_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++; if (res_out !== e) begin errors++; $display("FAIL b2b%0d_res got %h exp %h", got, res_out, e); end
                got++;
            end
            if (in_ready && sent < 5) begin
                op = spread(rnd128());
                in_valid = 1'b1;
                sq_in    = op;
                exp_q.push_back(ref_reduce(op));
                acc = cyc + 1;
                if (sent > 0) begin
                    checks++; if (acc - prev != 6) begin errors++; $display("FAIL b2b%0d_spacing got %0d exp 6", sent, acc - prev); end
                end
                prev = acc;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (got != 5) begin errors++; $display("FAIL b2b_count got %0d exp 5", got); end
    endtask

    task automatic test_backpressure();
        logic [127:0] held, e;
        int acc, seen;
        bit ok;
        out_ready = 1'b0;
        accept_op(256'd1 << 254, acc, ok);
        wait_valid(ok, seen);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL bp_out_valid got timeout exp out_valid");
        end else begin
            held = res_out;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            checks++; if (held !== e) begin errors++; $display("FAIL bp_res got %h exp %h", held, e); end
            in_valid = 1'b1;                 // must be ignored outside IDLE
            sq_in    = spread(rnd128());
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || res_out !== e)
                    begin errors++; $display("FAIL bp_hold%0d got v=%b r=%b res=%h exp 1/0/%h", k, out_valid, in_ready, res_out, e); end
            end
            out_ready = 1'b1;
            in_valid  = 1'b0;
            @(negedge clk);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
        end
    endtask

    task automatic test_reset_mid_fold();
        logic [127:0] e;
        int acc, seen;
        bit ok;
        out_ready = 1'b1;
        accept_op(256'd1 << 254, acc, ok);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || res_out !== 128'h0)
            begin errors++; $display("FAIL midrst_outputs got r=%b v=%b b=%b res=%h exp 1/0/0/0", in_ready, out_valid, busy, res_out); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_spurious%0d got %b exp 0", k, out_valid); end
        end
        accept_op(256'd1 << 128, acc, ok);
        wait_valid(ok, seen);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midrst_out_valid got timeout exp out_valid");
        end else begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
            checks++; if (res_out !== 128'h87 || res_out !== e) begin errors++; $display("FAIL midrst_res got %h exp 87", res_out); end
            @(negedge clk);
        end
    endtask

`ifdef GF_SQR_CHECK_EN
    task automatic test_odd_err();
        logic [255:0] ops[3];
        logic [127:0] e;
        logic         exp_err[3];
        int acc, seen;
        bit ok;
        ops[0] = 256'h2; exp_err[0] = 1'b1;
        ops[1] = 256'h1; exp_err[1] = 1'b1;   // sticky
        ops[2] = 256'h1; exp_err[2] = 1'b0;   // after reset
        out_ready = 1'b1;
        rst = 1'b1; #1;
        checks++; if (odd_err !== 1'b0) begin errors++; $display("FAIL odd_reset got %b exp 0", odd_err); end
        @(negedge clk); rst = 1'b0; @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
            end
            accept_op(ops[i], acc, ok);
            checks++; if (odd_err !== exp_err[i]) begin errors++; $display("FAIL odd%0d_flag got %b exp %b", i, odd_err, exp_err[i]); end
            wait_valid(ok, seen);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL odd%0d_out_valid got timeout exp out_valid", i);
            end else begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                checks++; if (res_out !== e) begin errors++; $display("FAIL odd%0d_res got %h exp %h", i, res_out, e); end
                checks++; if (odd_err !== exp_err[i]) begin errors++; $display("FAIL odd%0d_hold got %b exp %b", i, odd_err, exp_err[i]); end
                @(negedge clk);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_fold();
`ifdef GF_SQR_CHECK_EN
        test_odd_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
